// File: rtl/alu_op_sequencer.sv
// Command/result sequencer wrapped around a combinational alu32.
// Registers the ALU operands, captures the ALU result one cycle later and returns it over a valid/ready channel.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_v,
    input  logic             alu_z,
    input  logic             alu_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_out,
    output logic             res_v,
    output logic             res_z,
    output logic             res_cout,
    output logic             res_err,
    output logic             sticky_v,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    // state  | meaning
    // IDLE   | waiting for a command
    // ISSUE  | operands driven to alu32, result captured at end of cycle
    // RESP   | result held on res_* until consumed
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic [2:0]         r_alu_sel;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_out;
    logic               r_res_v;
    logic               r_res_z;
    logic               r_res_cout;
    logic               r_res_err;
    logic               r_sticky_v;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_cmd_ready;
    logic               w_cmd_hs;
    logic               w_res_hs;
    logic               w_sel_illegal;
    logic               w_sticky_set;

    // Ready is held low during reset even though the state register already reads IDLE.
    assign w_cmd_ready   = rst_n & ((r_state == S_IDLE) | ((r_state == S_RESP) & res_ready));
    assign w_cmd_hs      = cmd_valid & w_cmd_ready;
    assign w_res_hs      = r_res_valid & res_ready;
    assign w_sel_illegal = (r_alu_sel == 3'b011) | (r_alu_sel == 3'b100) | (r_alu_sel == 3'b101);
    assign w_sticky_set  = (r_state == S_ISSUE) & ~w_sel_illegal & alu_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 3'b000;
            r_res_valid <= 1'b0;
            r_res_out   <= '0;
            r_res_v     <= 1'b0;
            r_res_z     <= 1'b0;
            r_res_cout  <= 1'b0;
            r_res_err   <= 1'b0;
            r_sticky_v  <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_alu_a   <= cmd_a;
                        r_alu_b   <= cmd_b;
                        r_alu_sel <= cmd_sel;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_res_valid <= 1'b1;
                    r_state     <= S_RESP;
                    if (w_sel_illegal) begin
                        r_res_out  <= '0;
                        r_res_v    <= 1'b0;
                        r_res_z    <= 1'b0;
                        r_res_cout <= 1'b0;
                        r_res_err  <= 1'b1;
                    end else begin
                        r_res_out  <= alu_out;
                        r_res_v    <= alu_v;
                        r_res_z    <= alu_z;
                        r_res_cout <= alu_cout;
                        r_res_err  <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (w_res_hs) begin
                        r_res_valid <= 1'b0;
                        r_op_count  <= r_op_count + CNT_W'(1);
                        if (w_cmd_hs) begin
                            r_alu_a   <= cmd_a;
                            r_alu_b   <= cmd_b;
                            r_alu_sel <= cmd_sel;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Clear beats a same-edge overflow capture.
            if (sticky_clr) begin
                r_sticky_v <= 1'b0;
            end else if (w_sticky_set) begin
                r_sticky_v <= 1'b1;
            end
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_out   = r_res_out;
    assign res_v     = r_res_v;
    assign res_z     = r_res_z;
    assign res_cout  = r_res_cout;
    assign res_err   = r_res_err;
    assign sticky_v  = r_sticky_v;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural alu32 stand-in.
// Expected results come from an arithmetic reference model of the ALU operations.
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] out;
        logic        v;
        logic        z;
        logic        c;
        logic        err;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_sel = 3'b000;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_v;
    logic             alu_z;
    logic             alu_cout;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_out;
    logic             res_v;
    logic             res_z;
    logic             res_cout;
    logic             res_err;
    logic             sticky_v;
    logic             sticky_clr = 1'b0;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int failures = 0;
    bit sticky_ref = 1'b0;
    int cnt_ref = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_v(alu_v), .alu_z(alu_z), .alu_cout(alu_cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_v(res_v), .res_z(res_z), .res_cout(res_cout),
        .res_err(res_err), .sticky_v(sticky_v), .sticky_clr(sticky_clr),
        .op_count(op_count)
    );

    // alu32 stand-in; illegal selects produce junk that the sequencer must suppress.
    always_comb begin
        logic [32:0] sum;
        sum      = '0;
        alu_out  = '0;
        alu_v    = 1'b0;
        alu_cout = 1'b0;
        case (alu_sel)
            3'b000: alu_out = alu_a & alu_b;
            3'b001: alu_out = alu_a | alu_b;
            3'b010: begin
                sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out  = sum[31:0];
                alu_cout = sum[32];
                alu_v    = (alu_a[31] ~^ alu_b[31]) & (sum[31] ^ alu_a[31]);
            end
            3'b110: begin
                sum      = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_out  = sum[31:0];
                alu_cout = sum[32];
                alu_v    = (alu_a[31] ^ alu_b[31]) & (sum[31] ^ alu_a[31]);
            end
            3'b111: begin
                sum     = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_out = {31'd0, sum[31] ^ ((alu_a[31] ^ alu_b[31]) & (sum[31] ^ alu_a[31]))};
            end
            default: begin
                alu_out  = alu_a ^ alu_b;
                alu_v    = 1'b1;
                alu_cout = 1'b1;
            end
        endcase
        alu_z = (alu_out == 32'd0);
    end

    function automatic res_t ref_alu(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        res_t r;
        longint sa, sb, sr;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (sel)
            3'b000: r.out = a & b;
            3'b001: r.out = a | b;
            3'b010: begin
                sr    = sa + sb;
                r.out = a + b;
                r.c   = (longint'(a) + longint'(b)) > 64'sd4294967295;
                r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b110: begin
                sr    = sa - sb;
                r.out = a - b;
                r.c   = (a >= b);
                r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'b111: r.out = (sa < sb) ? 32'd1 : 32'd0;
            default: r.err = 1'b1;
        endcase
        if (!r.err) r.z = (r.out == 32'd0);
        return r;
    endfunction

    function automatic void model_commit(input res_t e);
        if (!e.err && e.v) sticky_ref = 1'b1;
        cnt_ref++;
    endfunction

    // Stimulus only: issues one command, waits for the result, holds it for 'hold' cycles, consumes it.
    task automatic do_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output res_t got, output int lat, output bit ok);
        ok  = 1'b1;
        lat = 0;
        got = '0;
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        res_ready = 1'b0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            @(posedge clk); #1;
        end
        if (!cmd_ready) begin
            ok = 1'b0;
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) begin
            ok = 1'b0;
            return;
        end
        got = {res_out, res_v, res_z, res_cout, res_err};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=0", cmd_ready); end
        checks++; if (op_count !== 4'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        checks++; if ({alu_a, alu_b, alu_sel} !== '0) begin failures++; $display("FAIL reset_alu_regs got=%h/%h/%b exp=0", alu_a, alu_b, alu_sel); end
        checks++; if ({res_out, res_v, res_z, res_cout, res_err, sticky_v} !== '0) begin failures++; $display("FAIL reset_res got=%h v%b z%b c%b e%b s%b exp=0", res_out, res_v, res_z, res_cout, res_err, sticky_v); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready got=%0b exp=1", cmd_ready); end
        sticky_ref = 1'b0;
        cnt_ref = 0;
    endtask

    task automatic test_directed;
        logic [2:0]  sels [4] = '{3'b010, 3'b000, 3'b111, 3'b110};
        logic [31:0] as   [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hC000_0001, 32'h0000_0005};
        logic [31:0] bs   [4] = '{32'h0000_0001, 32'h0000_0001, 32'hC000_0004, 32'h0000_0005};
        logic [31:0] outs [4] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};
        logic        zs   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        res_t got, exp;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(sels[i], as[i], bs[i], 0, got, lat, ok);
            exp = ref_alu(sels[i], as[i], bs[i]);
            model_commit(exp);
            checks++; if (!ok) begin failures++; $display("FAIL dir%0d_timeout got=timeout exp=result", i); end
            checks++; if (lat !== 2) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=2", i, lat); end
            checks++; if (got.out !== outs[i] || got.z !== zs[i]) begin failures++; $display("FAIL dir%0d_out got=%h z%b exp=%h z%b", i, got.out, got.z, outs[i], zs[i]); end
            checks++; if (got !== exp) begin failures++; $display("FAIL dir%0d_model got=%h exp=%h", i, got, exp); end
            if (i == 0) begin
                checks++; if (got.v !== 1'b1 || sticky_v !== 1'b1) begin failures++; $display("FAIL add_ovf_sticky got=v%b s%b exp=v1 s1", got.v, sticky_v); end
            end
            checks++; if (op_count !== 4'(cnt_ref)) begin failures++; $display("FAIL dir%0d_op_count got=%0d exp=%0d", i, op_count, 4'(cnt_ref)); end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        int guard;
        cmd_sel = 3'b010; cmd_a = 32'd100; cmd_b = 32'd23; cmd_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk); #1;
        cmd_a = 32'hDEAD_BEEF; cmd_sel = 3'b001;
        guard = 0;
        while (!res_valid && guard < 10) begin @(posedge clk); #1; guard++; end
        checks++; if (!res_valid) begin failures++; $display("FAIL bp_no_result got=0 exp=1"); end
        held = res_out;
        checks++; if (held !== 32'd123) begin failures++; $display("FAIL bp_value got=%h exp=%h", held, 32'd123); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (res_valid !== 1'b1 || res_out !== held || cmd_ready !== 1'b0 || alu_a !== 32'd100) begin
                failures++; $display("FAIL bp_hold%0d got=vld%b out=%h rdy%b a=%h exp=vld1 out=%h rdy0 a=%h", i, res_valid, res_out, cmd_ready, alu_a, held, 32'd100);
            end
        end
        cnt_ref++;
        cmd_sel = 3'b110; cmd_a = 32'd5; cmd_b = 32'd5; res_ready = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_comb got=%0b exp=1", cmd_ready); end
        @(posedge clk); #1;
        res_ready = 1'b0; cmd_valid = 1'b0;
        checks++; if (res_valid !== 1'b0 || op_count !== 4'(cnt_ref) || alu_a !== 32'd5 || alu_sel !== 3'b110) begin
            failures++; $display("FAIL bp_dual_hs got=vld%b cnt%0d a=%h sel%b exp=vld0 cnt%0d a=5 sel110", res_valid, op_count, alu_a, alu_sel, 4'(cnt_ref));
        end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b1 || res_out !== 32'd0 || res_z !== 1'b1) begin failures++; $display("FAIL bp_sub_result got=vld%b out=%h z%b exp=vld1 out=0 z1", res_valid, res_out, res_z); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        cnt_ref++;
        checks++; if (op_count !== 4'(cnt_ref)) begin failures++; $display("FAIL bp_op_count got=%0d exp=%0d", op_count, 4'(cnt_ref)); end
    endtask

    task automatic test_illegal;
        logic [2:0] ill [3] = '{3'b011, 3'b100, 3'b101};
        res_t got;
        int lat;
        bit ok;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        sticky_ref = 1'b0;
        checks++; if (sticky_v !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%0b exp=0", sticky_v); end
        for (int i = 0; i < 3; i++) begin
            do_op(ill[i], 32'h7FFF_FFFF, 32'h0000_0001, 1, got, lat, ok);
            cnt_ref++;
            checks++; if (!ok || got !== {32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin failures++; $display("FAIL illegal%0d got=%h ok%0b exp=%h", i, got, ok, {32'd0, 4'b0001}); end
            checks++; if (alu_sel !== ill[i] || sticky_v !== 1'b0 || op_count !== 4'(cnt_ref)) begin
                failures++; $display("FAIL illegal%0d_side got=sel%b s%b cnt%0d exp=sel%b s0 cnt%0d", i, alu_sel, sticky_v, op_count, ill[i], 4'(cnt_ref));
            end
        end
    endtask

    task automatic test_random;
        res_t got, exp;
        int lat;
        bit ok;
        logic [2:0]  sel;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            sel = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            do_op(sel, a, b, $urandom_range(0, 3), got, lat, ok);
            exp = ref_alu(sel, a, b);
            model_commit(exp);
            checks++; if (!ok || lat !== 2 || got !== exp) begin failures++; $display("FAIL rand%0d sel%b a=%h b=%h got=%h lat%0d exp=%h lat2", i, sel, a, b, got, lat, exp); end
            checks++; if (sticky_v !== sticky_ref || op_count !== 4'(cnt_ref) || res_valid !== 1'b0 || alu_a !== a || alu_b !== b) begin
                failures++; $display("FAIL rand%0d_state got=s%b cnt%0d vld%b exp=s%b cnt%0d vld0", i, sticky_v, op_count, res_valid, sticky_ref, 4'(cnt_ref));
            end
        end
    endtask

    task automatic test_sticky_clr;
        cmd_sel = 3'b010; cmd_a = 32'h7FFF_FFFF; cmd_b = 32'h0000_0001; cmd_valid = 1'b1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL clr_ready got=%0b exp=1", cmd_ready); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        sticky_ref = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_v !== 1'b1 || sticky_v !== 1'b0) begin failures++; $display("FAIL clr_vs_set got=vld%b v%b s%b exp=vld1 v1 s0", res_valid, res_v, sticky_v); end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        cnt_ref++;
        checks++; if (sticky_v !== 1'b0 || op_count !== 4'(cnt_ref)) begin failures++; $display("FAIL clr_after got=s%b cnt%0d exp=s0 cnt%0d", sticky_v, op_count, 4'(cnt_ref)); end
    endtask

    task automatic test_reset_mid;
        cmd_sel = 3'b010; cmd_a = 32'h1234_5678; cmd_b = 32'h1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++; if (alu_sel !== 3'b010 || res_valid !== 1'b0) begin failures++; $display("FAIL mid_issue got=sel%b vld%b exp=sel010 vld0", alu_sel, res_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || op_count !== 4'd0 || alu_sel !== 3'b000 || cmd_ready !== 1'b0 || alu_a !== 32'd0) begin
            failures++; $display("FAIL mid_reset got=vld%b cnt%0d sel%b rdy%b a=%h exp=vld0 cnt0 sel000 rdy0 a=0", res_valid, op_count, alu_sel, cmd_ready, alu_a);
        end
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_hold got=%0b exp=0", res_valid); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        sticky_ref = 1'b0;
        cnt_ref = 0;
        checks++; if (cmd_ready !== 1'b1 || sticky_v !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL post_reset got=rdy%b s%b vld%b exp=rdy1 s0 vld0", cmd_ready, sticky_v, res_valid); end
    endtask

    task automatic test_wrap;
        res_t got, exp;
        int lat;
        bit ok;
        for (int i = 0; i < 16; i++) begin
            do_op(3'b001, 32'(i), 32'h100, 0, got, lat, ok);
            exp = ref_alu(3'b001, 32'(i), 32'h100);
            model_commit(exp);
            checks++; if (!ok || got !== exp || op_count !== 4'(cnt_ref)) begin
                failures++; $display("FAIL wrap%0d got=%h cnt%0d exp=%h cnt%0d", i, got, op_count, exp, 4'(cnt_ref));
            end
        end
        checks++; if (op_count !== 4'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", op_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_illegal;
        test_random;
        test_sticky_clr;
        test_reset_mid;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
